// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: FSM encodings
// and default widths/limits used by the interface and the arbiter.
package rf_wport_arbiter_pkg;

  localparam int ARB_DATA_W   = 32;
  localparam int ARB_RF_AW    = 5;
  localparam int ARB_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PEND  = 2'd1,
    ARB_STALL = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bundle of WB/LU request, register-file write and pipeline feedback signals
// around the write-port arbiter; slave is the arbiter side.
interface rf_wport_arbiter_if
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W,
  parameter int RF_AW  = ARB_RF_AW
);

  logic              wb_req_wen;
  logic [RF_AW-1:0]  wb_req_waddr;
  logic [DATA_W-1:0] wb_req_wdata;
  logic              lu_valid;
  logic [RF_AW-1:0]  lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic              lu_ready;
  logic              rf_wen;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;
  logic              pend_valid;
  logic [RF_AW-1:0]  pend_waddr;
  logic              waw_kill;

  modport slave (
    input  wb_req_wen, wb_req_waddr, wb_req_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output stall_req, pend_valid, pend_waddr, waw_kill
  );

  modport master (
    output wb_req_wen, wb_req_waddr, wb_req_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  stall_req, pend_valid, pend_waddr, waw_kill
  );

endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between WB (always wins) and the
// long-latency unit, via a zero-latency bypass or a one-entry pending buffer.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DATA_W   = ARB_DATA_W,
  parameter int RF_AW    = ARB_RF_AW,
  parameter int MAX_WAIT = ARB_MAX_WAIT
) (
  input  logic               clk,
  input  logic               rst,
  rf_wport_arbiter_if.slave  bus
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  arb_state_t        state_reg,     state_next;
  logic              buf_valid_reg, buf_valid_next;
  logic [RF_AW-1:0]  buf_waddr_reg, buf_waddr_next;
  logic [DATA_W-1:0] buf_wdata_reg, buf_wdata_next;
  logic [3:0]        wait_cnt_reg,  wait_cnt_next;

  logic lu_ready;
  logic wb_act;
  logic lu_acc;
  logic waw_hit;

  assign lu_ready = (state_reg == ARB_IDLE);
  assign wb_act   = bus.wb_req_wen && (bus.wb_req_waddr != '0);
  assign lu_acc   = bus.lu_valid && lu_ready;
  // A WB write to the buffered destination is younger and supersedes it.
  assign waw_hit  = buf_valid_reg && wb_act && (bus.wb_req_waddr == buf_waddr_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ARB_IDLE;
      buf_valid_reg <= 1'b0;
      buf_waddr_reg <= '0;
      buf_wdata_reg <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      buf_waddr_reg <= buf_waddr_next;
      buf_wdata_reg <= buf_wdata_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg;
    buf_waddr_next = buf_waddr_reg;
    buf_wdata_next = buf_wdata_reg;
    wait_cnt_next  = wait_cnt_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (lu_acc && wb_act && (bus.lu_waddr != '0)) begin
          buf_valid_next = 1'b1;
          buf_waddr_next = bus.lu_waddr;
          buf_wdata_next = bus.lu_wdata;
          wait_cnt_next  = '0;
          state_next     = ARB_PEND;
        end
      end
      ARB_PEND, ARB_STALL: begin
        // Either the slot is free (drain) or WB overwrote the same register.
        if (!wb_act || waw_hit) begin
          buf_valid_next = 1'b0;
          wait_cnt_next  = '0;
          state_next     = ARB_IDLE;
        end else if (state_reg == ARB_PEND) begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next = ARB_STALL;
          end
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Write mux is gated by reset so the RF sees no write while reset is held.
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (rst) begin
      if (wb_act) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = bus.wb_req_waddr;
        bus.rf_wdata = bus.wb_req_wdata;
      end else if (buf_valid_reg) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = buf_waddr_reg;
        bus.rf_wdata = buf_wdata_reg;
      end else if (lu_acc && (bus.lu_waddr != '0)) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = bus.lu_waddr;
        bus.rf_wdata = bus.lu_wdata;
      end
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.stall_req  = (state_reg == ARB_STALL);
  assign bus.pend_valid = buf_valid_reg;
  assign bus.pend_waddr = buf_waddr_reg;
  assign bus.waw_kill   = rst && waw_hit;

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Shares the register file's single write port between the in-order WB stage and a long-latency unit (LU: multi-cycle mul/div, non-blocking load return).
- WB always has priority and is never back-pressured.
- LU results are written in a free slot, either directly or from a one-entry pending buffer.
- A starvation counter asks the pipeline to insert a bubble when the LU waits too long.
- Sits between WB/LU and the register file. Exports pending-write info to ID hazard detection.

Parameters:
- DATA_W, 32, register data width (matches DATA_RANGE)
- RF_AW, 5, register address width (matches RF_RANGE)
- MAX_WAIT, 4, cycles a buffered LU result may be blocked before stall_req asserts (legal range 1..15)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- wb_req_wen  in  1  WB write request
- wb_req_waddr  in  RF_AW  WB destination register
- wb_req_wdata  in  DATA_W  WB write data
- lu_valid  in  1  LU result valid
- lu_waddr  in  RF_AW  LU destination register
- lu_wdata  in  DATA_W  LU result data
- lu_ready  out  1  arbiter can accept an LU result this cycle
- rf_wen  out  1  register file write enable
- rf_waddr  out  RF_AW  register file write address
- rf_wdata  out  DATA_W  register file write data
- stall_req  out  1  request to pipeline: next WB slot must be a bubble
- pend_valid  out  1  buffered LU write outstanding
- pend_waddr  out  RF_AW  destination of buffered LU write
- waw_kill  out  1  one-cycle pulse: buffered entry discarded by a WB WAW

Behaviour:
- Definitions:
  - wb_act = wb_req_wen && wb_req_waddr!=0. A WB write to x0 counts as a free slot and is never forwarded.
  - lu_acc = lu_valid && lu_ready.
- State: buf_valid/buf_waddr/buf_wdata, wait_cnt[3:0], FSM {IDLE, PEND, STALL}.
- Reset (rst=0, async):
  - FSM=IDLE, buf_valid=0, wait_cnt=0.
  - Outputs: rf_wen=0, stall_req=0, pend_valid=0, waw_kill=0, lu_ready=1.
  - Address/data outputs = 0.
  - Reset mid-operation drops any buffered result.
- lu_ready = (FSM==IDLE). It is a function of registered state only, with no combinational path from the inputs.
- Write mux (combinational):
  - If wb_act: WB data is written.
  - Else if buf_valid: buffer is written (drain).
  - Else if lu_acc && lu_waddr!=0: LU result is written the same cycle (bypass, zero latency).
  - Else rf_wen=0.
- IDLE:
  - lu_acc && !wb_act: bypass write, stay IDLE.
  - lu_acc && wb_act && lu_waddr!=0: load buffer, wait_cnt=0, go to PEND.
  - lu_acc with lu_waddr==0: result discarded, stay IDLE.
- PEND:
  - Slot free (!wb_act): drain, buf_valid=0, go to IDLE the next cycle.
  - Slot taken: wait_cnt++. When wait_cnt==MAX_WAIT-1 on a blocked cycle, go to STALL.
- STALL:
  - stall_req=1, registered, asserted from the first STALL cycle.
  - Held until the drain cycle. Drain proceeds as in PEND, then the next state is IDLE with stall_req=0 and wait_cnt=0.
- WAW rule:
  - In PEND or STALL, if wb_act && wb_req_waddr==buf_waddr, WB is the younger write.
  - The WB write proceeds and the buffer is discarded: buf_valid=0, waw_kill=1 for one cycle, next state IDLE, stall_req deasserts.
- pend_valid = buf_valid and pend_waddr = buf_waddr, both registered.
- No write is ever lost except by x0 suppression or the WAW kill. At most one write occurs per cycle.

Decomposition:
- Widths come from the shared core header (DATA_RANGE, RF_RANGE).
- Add the FSM state encodings (ARB_IDLE, ARB_PEND, ARB_STALL) and the MAX_WAIT default to core.vh.
- Single flat module; no sub-module is warranted, since the buffer is one register plus a counter.

Test Plan:
- Reset released, WB idle, LU pulses x5=0xDEADBEEF -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the same cycle; pend_valid stays 0.
- WB writes x3=0x11 while LU delivers x7=0x22 -> x3 written in cycle N; lu_ready=0 in N+1; x7 written in N+1 when WB is idle; pend_valid high for exactly one cycle.
- MAX_WAIT=4, WB busy every cycle after LU x9 is buffered -> stall_req rises after 4 blocked cycles; the first WB bubble writes x9 in that slot; stall_req is 0 the next cycle.
- Buffered x4=0xAA, then WB writes x4=0xBB -> rf_wdata=0xBB; waw_kill pulses once; 0xAA is never written; lu_ready=1 the next cycle.
- WB wen=1 with waddr=0 while buffer holds x6 -> the slot counts as free, x6 is drained, and no write to x0 occurs.
- LU result x8 buffered, rst driven low mid-PEND -> all outputs are 0 immediately; after release lu_ready=1 and x8 is never written.
